// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone address decoder: FSM encoding, error data
// and the default slave window map.
package wb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StError
    } wb_state_e;

    localparam logic [31:0] ErrData   = 32'hFFFF_FFFF;

    localparam logic [31:0] DefS0Base = 32'h0000_0000;
    localparam logic [31:0] DefS0Mask = 32'hF000_0000;
    localparam logic [31:0] DefS1Base = 32'h8000_0000;
    localparam logic [31:0] DefS1Mask = 32'hFF00_0000;
    localparam logic [31:0] DefS2Base = 32'h8100_0000;
    localparam logic [31:0] DefS2Mask = 32'hFF00_0000;
    localparam logic [31:0] DefS3Base = 32'h8200_0000;
    localparam logic [31:0] DefS3Mask = 32'hFF00_0000;

endpackage

// File: rtl/wb_addr_match.sv
// Base/mask window compare for four slave windows; the lowest matching
// window index wins when windows overlap.
module wb_addr_match #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hF000_0000,
    parameter logic [31:0] S1_BASE = 32'h8000_0000,
    parameter logic [31:0] S1_MASK = 32'hFF00_0000,
    parameter logic [31:0] S2_BASE = 32'h8100_0000,
    parameter logic [31:0] S2_MASK = 32'hFF00_0000,
    parameter logic [31:0] S3_BASE = 32'h8200_0000,
    parameter logic [31:0] S3_MASK = 32'hFF00_0000
) (
    input  logic [31:0] adr,
    output logic [3:0]  hit,
    output logic [1:0]  idx
);

    always_comb begin
        hit[0] = (adr & S0_MASK) == S0_BASE;
        hit[1] = (adr & S1_MASK) == S1_BASE;
        hit[2] = (adr & S2_MASK) == S2_BASE;
        hit[3] = (adr & S3_MASK) == S3_BASE;
    end

    // Scan from the top so the lowest set bit is written last.
    always_comb begin
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) begin
                idx = 2'(i);
            end
        end
    end

endmodule

// File: rtl/wb_decoder.sv
// Wishbone address decoder and bus watchdog: routes the granted-master cycle to
// one of four slaves and error-terminates unmapped or unresponsive accesses.
module wb_decoder import wb_pkg::*; #(
    parameter logic [31:0] S0_BASE = DefS0Base,
    parameter logic [31:0] S0_MASK = DefS0Mask,
    parameter logic [31:0] S1_BASE = DefS1Base,
    parameter logic [31:0] S1_MASK = DefS1Mask,
    parameter logic [31:0] S2_BASE = DefS2Base,
    parameter logic [31:0] S2_MASK = DefS2Mask,
    parameter logic [31:0] S3_BASE = DefS3Base,
    parameter logic [31:0] S3_MASK = DefS3Mask,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         wb_clk_i,
    input  logic         wb_rstn_i,
    input  logic [31:0]  wbm_adr_i,
    input  logic [31:0]  wbm_dat_i,
    input  logic         wbm_cyc_i,
    input  logic         wbm_stb_i,
    input  logic         wbm_we_i,
    input  logic [2:0]   wbm_cti_i,
    input  logic [1:0]   wbm_bte_i,
    input  logic [3:0]   wbm_sel_i,
    input  logic [1:0]   wbm_owner_i,
    output logic [31:0]  wbm_dat_o,
    output logic         wbm_ack_o,
    output logic [31:0]  wbs_adr_o,
    output logic [31:0]  wbs_dat_o,
    output logic         wbs_we_o,
    output logic [2:0]   wbs_cti_o,
    output logic [1:0]   wbs_bte_o,
    output logic [3:0]   wbs_sel_o,
    output logic [3:0]   wbs_cyc_o,
    output logic [3:0]   wbs_stb_o,
    input  logic [127:0] wbs_dat_i,
    input  logic [3:0]   wbs_ack_i,
    output logic         err_o,
    output logic [31:0]  err_adr_o,
    output logic [1:0]   err_owner_o,
    output logic         err_timeout_o,
    output logic [7:0]   err_cnt_o
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    wb_state_e   state_q, state_d;
    logic [1:0]  slv_q, slv_d;
    logic [7:0]  wait_q, wait_d;
    logic        err_ack_q, err_ack_d;
    logic        err_q;
    logic [31:0] err_adr_q;
    logic [1:0]  err_owner_q;
    logic        err_tmo_q;
    logic [7:0]  err_cnt_q;

    logic [3:0]  hit;
    logic [1:0]  hit_idx;
    logic        req;
    logic        slv_ack;
    logic [31:0] slv_dat;
    logic        err_entry;
    logic        err_tmo;

    wb_addr_match #(
        .S0_BASE(S0_BASE), .S0_MASK(S0_MASK),
        .S1_BASE(S1_BASE), .S1_MASK(S1_MASK),
        .S2_BASE(S2_BASE), .S2_MASK(S2_MASK),
        .S3_BASE(S3_BASE), .S3_MASK(S3_MASK)
    ) u_addr_match (
        .adr (wbm_adr_i),
        .hit (hit),
        .idx (hit_idx)
    );

    assign req     = wbm_cyc_i & wbm_stb_i;
    assign slv_ack = wbs_ack_i[slv_q];
    assign slv_dat = wbs_dat_i[{slv_q, 5'd0} +: 32];

    assign wbs_adr_o = wbm_adr_i;
    assign wbs_dat_o = wbm_dat_i;
    assign wbs_we_o  = wbm_we_i;
    assign wbs_cti_o = wbm_cti_i;
    assign wbs_bte_o = wbm_bte_i;
    assign wbs_sel_o = wbm_sel_i;

    always_comb begin
        state_d   = state_q;
        slv_d     = slv_q;
        wait_d    = wait_q;
        err_entry = 1'b0;
        err_tmo   = 1'b0;
        unique case (state_q)
            StIdle: begin
                wait_d = 8'd0;
                if (req) begin
                    if (|hit) begin
                        slv_d   = hit_idx;
                        state_d = StActive;
                    end else begin
                        state_d   = StError;
                        err_entry = 1'b1;
                    end
                end
            end
            StActive: begin
                if (!wbm_cyc_i) begin
                    state_d = StIdle;
                    wait_d  = 8'd0;
                end else if (wbm_stb_i && !slv_ack) begin
                    // A same-edge ack takes the else branch, so it beats the timeout.
                    if (wait_q == TimeoutLast) begin
                        state_d   = StError;
                        err_entry = 1'b1;
                        err_tmo   = 1'b1;
                        wait_d    = 8'd0;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end else begin
                    wait_d = 8'd0;
                end
            end
            StError: begin
                wait_d = 8'd0;
                if (!wbm_cyc_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Error acks alternate so every burst beat is terminated at most every other cycle.
    assign err_ack_d = (state_q == StError) && wbm_stb_i && !err_ack_q;

    always_comb begin
        wbs_cyc_o = 4'd0;
        wbs_stb_o = 4'd0;
        wbm_ack_o = 1'b0;
        wbm_dat_o = ErrData;
        if (wb_rstn_i) begin
            unique case (state_q)
                StIdle: begin
                    if (req && |hit) begin
                        wbs_cyc_o[hit_idx] = wbm_cyc_i;
                        wbs_stb_o[hit_idx] = wbm_stb_i;
                    end
                end
                StActive: begin
                    wbs_cyc_o[slv_q] = wbm_cyc_i;
                    wbs_stb_o[slv_q] = wbm_stb_i;
                    wbm_ack_o        = slv_ack;
                    wbm_dat_o        = slv_dat;
                end
                StError: wbm_ack_o = err_ack_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q   <= StIdle;
            slv_q     <= 2'd0;
            wait_q    <= 8'd0;
            err_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slv_q     <= slv_d;
            wait_q    <= wait_d;
            err_ack_q <= err_ack_d;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            err_q       <= 1'b0;
            err_adr_q   <= 32'd0;
            err_owner_q <= 2'd0;
            err_tmo_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            err_q <= err_entry;
            if (err_entry) begin
                err_adr_q   <= wbm_adr_i;
                err_owner_q <= wbm_owner_i;
                err_tmo_q   <= err_tmo;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign err_o         = err_q;
    assign err_adr_o     = err_adr_q;
    assign err_owner_o   = err_owner_q;
    assign err_timeout_o = err_tmo_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_wb_decoder.sv
// Randomized self-checking bench for wb_decoder: each transaction's cycle-by-cycle
// outcome is planned from the window map and latency rules, then compared.
module tb_wb_decoder;

    localparam int          Tmo  = 4;
    localparam logic [31:0] ErrD = 32'hFFFF_FFFF;

    logic         wb_clk = 1'b0;
    logic         wb_rstn;
    logic [31:0]  wbm_adr, wbm_dat;
    logic         wbm_cyc, wbm_stb, wbm_we;
    logic [2:0]   wbm_cti;
    logic [1:0]   wbm_bte;
    logic [3:0]   wbm_sel;
    logic [1:0]   wbm_owner;
    logic [31:0]  wbm_dat_o;
    logic         wbm_ack_o;
    logic [31:0]  wbs_adr_o, wbs_dat_o;
    logic         wbs_we_o;
    logic [2:0]   wbs_cti_o;
    logic [1:0]   wbs_bte_o;
    logic [3:0]   wbs_sel_o, wbs_cyc_o, wbs_stb_o;
    logic [127:0] wbs_dat_i;
    logic [3:0]   wbs_ack;
    logic         err_o;
    logic [31:0]  err_adr_o;
    logic [1:0]   err_owner_o;
    logic         err_timeout_o;
    logic [7:0]   err_cnt_o;

    logic [31:0]  sdat [4];
    logic [31:0]  base_tbl [4];
    logic [31:0]  mask_tbl [4];
    int           lat [4];

    int           n_chk = 0;
    int           n_fail = 0;
    int           m_cnt;
    logic [31:0]  m_adr;
    logic [1:0]   m_owner;
    logic         m_tmo;

    assign wbs_dat_i = {sdat[3], sdat[2], sdat[1], sdat[0]};

    always #5 wb_clk = ~wb_clk;

    wb_decoder #(.TIMEOUT(Tmo)) dut (
        .wb_clk_i      (wb_clk),
        .wb_rstn_i     (wb_rstn),
        .wbm_adr_i     (wbm_adr),
        .wbm_dat_i     (wbm_dat),
        .wbm_cyc_i     (wbm_cyc),
        .wbm_stb_i     (wbm_stb),
        .wbm_we_i      (wbm_we),
        .wbm_cti_i     (wbm_cti),
        .wbm_bte_i     (wbm_bte),
        .wbm_sel_i     (wbm_sel),
        .wbm_owner_i   (wbm_owner),
        .wbm_dat_o     (wbm_dat_o),
        .wbm_ack_o     (wbm_ack_o),
        .wbs_adr_o     (wbs_adr_o),
        .wbs_dat_o     (wbs_dat_o),
        .wbs_we_o      (wbs_we_o),
        .wbs_cti_o     (wbs_cti_o),
        .wbs_bte_o     (wbs_bte_o),
        .wbs_sel_o     (wbs_sel_o),
        .wbs_cyc_o     (wbs_cyc_o),
        .wbs_stb_o     (wbs_stb_o),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_ack_i     (wbs_ack),
        .err_o         (err_o),
        .err_adr_o     (err_adr_o),
        .err_owner_o   (err_owner_o),
        .err_timeout_o (err_timeout_o),
        .err_cnt_o     (err_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_log();
        chk("err_adr", err_adr_o, m_adr);
        chk("err_owner", 32'(err_owner_o), 32'(m_owner));
        chk("err_tmo", 32'(err_timeout_o), 32'(m_tmo));
        chk("err_cnt", 32'(err_cnt_o), 32'(m_cnt));
    endtask

    // Beat b is acked lat[b] cycles after the previous ack (or after stb for beat 0).
    task automatic run_txn(input logic [31:0] adr, input logic [1:0] owner, input logic we,
                           input int nb);
        logic [3:0]  ecyc [64];
        bit          eack [64];
        bit          eerr [64];
        bit          dack [64];
        logic [31:0] edat [64];
        logic [31:0] cur;
        logic [3:0]  tmask;
        int          tgt, ent, ferr, t, last, beat;
        for (int k = 0; k < 64; k++) begin
            ecyc[k] = 4'd0; eack[k] = 0; eerr[k] = 0; dack[k] = 0; edat[k] = 32'd0;
        end
        tgt = -1;
        for (int n = 3; n >= 0; n--) begin
            if ((adr & mask_tbl[n]) == base_tbl[n]) tgt = n;
        end
        ent = -1; ferr = 0; t = 0; last = 0;
        if (tgt < 0) begin
            ent = 1;
        end else begin
            for (int b = 0; b < nb && ent < 0; b++) begin
                if (lat[b] - 1 >= Tmo) begin
                    ent  = t + Tmo + 1;
                    ferr = b;
                end else begin
                    t = t + lat[b];
                    eack[t] = 1; dack[t] = 1; edat[t] = sdat[tgt]; last = t;
                end
            end
        end
        if (ent >= 0) begin
            eerr[ent] = 1;
            for (int j = ferr; j < nb; j++) begin
                last = ent + 1 + 2 * (j - ferr);
                eack[last] = 1; edat[last] = ErrD;
            end
            m_adr   = adr + 32'(4 * ferr);
            m_owner = owner;
            m_tmo   = (tgt >= 0);
            if (m_cnt < 255) m_cnt++;
        end
        tmask = (tgt >= 0) ? 4'(1 << tgt) : 4'd0;
        for (int k = 0; k <= last; k++) begin
            ecyc[k] = (ent < 0 || k < ent) ? tmask : 4'd0;
        end

        beat = 0;
        cur  = adr;
        for (int k = 0; k <= last; k++) begin
            @(posedge wb_clk); #1;
            wbm_cyc = 1'b1; wbm_stb = 1'b1; wbm_we = we; wbm_owner = owner; wbm_adr = cur;
            wbm_cti = (nb == 1) ? 3'b000 : (beat == nb - 1) ? 3'b111 : 3'b010;
            wbm_dat = $urandom; wbm_sel = 4'($urandom); wbm_bte = 2'($urandom);
            wbs_ack = (4'($urandom) & ~tmask) | (dack[k] ? tmask : 4'd0);
            @(negedge wb_clk);
            chk("cyc_o", 32'(wbs_cyc_o), 32'(ecyc[k]));
            chk("stb_o", 32'(wbs_stb_o), 32'(ecyc[k]));
            chk("ack", 32'(wbm_ack_o), 32'(eack[k]));
            chk("err_pulse", 32'(err_o), 32'(eerr[k]));
            chk("bcast_adr", wbs_adr_o, cur);
            chk("bcast_ctl", {wbs_dat_o[19:0], wbs_we_o, wbs_cti_o, wbs_bte_o, wbs_sel_o},
                {wbm_dat[19:0], we, wbm_cti, wbm_bte, wbm_sel});
            if (k == 0) chk("idle_dat", wbm_dat_o, ErrD);
            if (eack[k]) begin
                chk("dat", wbm_dat_o, edat[k]);
                beat++;
                cur = cur + 32'd4;
            end
        end
        @(posedge wb_clk); #1;
        wbm_cyc = 1'b0; wbm_stb = 1'b0; wbs_ack = 4'd0;
        @(negedge wb_clk);
        chk("end_cyc_o", 32'(wbs_cyc_o), 32'd0);
        chk_log();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [31:0] a;
        int          cls, nb;
        base_tbl = '{32'h0000_0000, 32'h8000_0000, 32'h8100_0000, 32'h8200_0000};
        mask_tbl = '{32'hF000_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};
        for (int n = 0; n < 4; n++) sdat[n] = $urandom;
        m_cnt = 0; m_adr = 32'd0; m_owner = 2'd0; m_tmo = 1'b0;

        // Reset state, with a mapped request already on the bus.
        wb_rstn = 1'b0; wbm_cyc = 1'b1; wbm_stb = 1'b1; wbm_adr = 32'h8000_0000;
        wbm_dat = 32'd0; wbm_we = 1'b0; wbm_cti = 3'd0; wbm_bte = 2'd0; wbm_sel = 4'hF;
        wbm_owner = 2'd0; wbs_ack = 4'hF;
        #3;
        chk("rst_cyc_o", 32'(wbs_cyc_o), 32'd0);
        chk("rst_ack", 32'(wbm_ack_o), 32'd0);
        chk("rst_err_o", 32'(err_o), 32'd0);
        chk("rst_dat", wbm_dat_o, ErrD);
        chk_log();
        @(negedge wb_clk);
        wbm_cyc = 1'b0; wbm_stb = 1'b0; wbs_ack = 4'd0;
        @(negedge wb_clk);
        wb_rstn = 1'b1;

        // Slave 2 read, ack after 3 cycles.
        sdat[2] = 32'h1234_5678; lat[0] = 3;
        run_txn(32'h8100_0010, 2'd0, 1'b0, 1);
        // Incrementing burst of 4 on slave 0.
        lat = '{1, 1, 1, 1};
        run_txn(32'h0000_0100, 2'd1, 1'b0, 4);
        // Unmapped write from owner 3.
        run_txn(32'h9000_0000, 2'd3, 1'b1, 1);
        // Slave 1 never answers.
        lat[0] = 9;
        run_txn(32'h8000_0040, 2'd2, 1'b0, 1);
        // Ack on the edge the counter reaches the limit.
        lat[0] = Tmo;
        run_txn(32'h8100_0000, 2'd1, 1'b0, 1);

        // Reset while active on slave 3.
        @(posedge wb_clk); #1;
        wbm_cyc = 1'b1; wbm_stb = 1'b1; wbm_adr = 32'h8200_0000; wbs_ack = 4'd0;
        @(posedge wb_clk); #1;
        wbs_ack = 4'b1000;
        #1;
        chk("act_cyc_o", 32'(wbs_cyc_o), 32'h8);
        chk("act_ack", 32'(wbm_ack_o), 32'd1);
        wb_rstn = 1'b0;
        #1;
        m_cnt = 0; m_adr = 32'd0; m_owner = 2'd0; m_tmo = 1'b0;
        chk("mid_rst_cyc_o", 32'(wbs_cyc_o), 32'd0);
        chk("mid_rst_ack", 32'(wbm_ack_o), 32'd0);
        chk_log();
        @(posedge wb_clk); #1;
        wbm_cyc = 1'b0; wbm_stb = 1'b0; wbs_ack = 4'd0;
        @(negedge wb_clk);
        wb_rstn = 1'b1;
        lat[0] = 2;
        run_txn(32'h8000_0000, 2'd0, 1'b0, 1);

        // Random mix of windows, burst lengths and slave latencies.
        for (int i = 0; i < 150; i++) begin
            a   = $urandom;
            cls = $urandom_range(0, 4);
            case (cls)
                0: a[31:28] = 4'h0;
                1: a[31:24] = 8'h80;
                2: a[31:24] = 8'h81;
                3: a[31:24] = 8'h82;
                default: ;
            endcase
            nb = $urandom_range(1, 4);
            for (int b = 0; b < 4; b++) lat[b] = $urandom_range(1, 6);
            for (int n = 0; n < 4; n++) sdat[n] = $urandom;
            run_txn(a, 2'($urandom), 1'($urandom), nb);
        end

        // Drive the error counter into saturation.
        for (int i = 0; i < 260; i++) begin
            a = $urandom;
            a[31:24] = 8'h90;
            run_txn(a, 2'($urandom), 1'b1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_decoder.md
# wb_decoder

Address decoder and bus watchdog sitting directly downstream of the four-master Wishbone arbiter: it takes the single granted-master bus and routes each cycle to one of four slave windows. Per-beat data and acks pass through combinationally; the slave window is latched for the whole `cyc` so bursts stay on one slave. Unmapped addresses and slaves that never acknowledge are terminated with an error ack (data 0xFFFFFFFF), and the failing address and master are logged, so a dead peripheral cannot hang the arbiter.

## Interface
Parameters:
- `S0_BASE`, default 32'h0000_0000: window 0 base. `S0_MASK`, default 32'hF000_0000: window 0 mask.
- `S1_BASE`/`S1_MASK`, default 32'h8000_0000/32'hFF00_0000: window 1 base and mask.
- `S2_BASE`/`S2_MASK`, default 32'h8100_0000/32'hFF00_0000: window 2 base and mask.
- `S3_BASE`/`S3_MASK`, default 32'h8200_0000/32'hFF00_0000: window 3 base and mask.
- `TIMEOUT`, default 255, range 2..255: cycles without ack before abort.

Ports (clock: `wb_clk_i`; reset: `wb_rstn_i`; one clock; reset is asynchronous and active-low):
- `wb_clk_i` in 1: clock
- `wb_rstn_i` in 1: async active-low reset
- `wbm_adr_i`, `wbm_dat_i` in 32 each: from arbiter owner bus
- `wbm_cyc_i`, `wbm_stb_i`, `wbm_we_i` in 1 each
- `wbm_cti_i` in 3; `wbm_bte_i` in 2; `wbm_sel_i` in 4
- `wbm_owner_i` in 2: arbiter's current owner index
- `wbm_dat_o` out 32; `wbm_ack_o` out 1
- `wbs_adr_o`, `wbs_dat_o` out 32 each: broadcast to all slaves
- `wbs_we_o` out 1; `wbs_cti_o` out 3; `wbs_bte_o` out 2; `wbs_sel_o` out 4: broadcast
- `wbs_cyc_o`, `wbs_stb_o` out 4 each: one bit per slave
- `wbs_dat_i` in 128: slave n data on bits [32n+31:32n]
- `wbs_ack_i` in 4
- `err_o` out 1: one-cycle pulse on each error entry
- `err_adr_o` out 32: address of last error
- `err_owner_o` out 2: owner index at last error
- `err_timeout_o` out 1: last error was a timeout (0 means unmapped)
- `err_cnt_o` out 8: saturating error count

## Operation
- Hit for window n: `(wbm_adr_i & Sn_MASK) == Sn_BASE`. Lowest index wins on overlap.
- Broadcast outputs equal their `wbm_*` inputs at all times.
- FSM states: IDLE, ACTIVE, ERROR.
- IDLE:
  - `cyc&stb` with a hit: the decoded slave gets `cyc`/`stb` in the same cycle (combinational). The window is latched into `slv_q`; go to ACTIVE.
  - `cyc&stb` with a miss: go to ERROR, log the error.
- ACTIVE:
  - `wbs_cyc_o[slv_q] = wbm_cyc_i`; `wbs_stb_o[slv_q] = wbm_stb_i`.
  - `wbm_ack_o = wbs_ack_i[slv_q]`; `wbm_dat_o` = slave `slv_q` data.
  - Acks from unselected slaves are ignored.
  - 8-bit wait counter: increments each cycle with `stb & !ack`, clears on ack or when `stb` is low.
  - Counter reaching `TIMEOUT`: go to ERROR and log as a timeout.
  - `wbm_cyc_i` low: go to IDLE.
- ERROR:
  - All `wbs_cyc_o`/`wbs_stb_o` are 0.
  - `wbm_dat_o` = 32'hFFFF_FFFF.
  - `wbm_ack_o` is registered: 1 on a cycle where `wbm_stb_i` was high in the previous cycle and ack was not asserted in the previous cycle. Every burst beat therefore gets an error ack, with a minimum 2-cycle spacing.
  - Leave to IDLE only when `wbm_cyc_i` is low.
- Error logging, on the cycle of ERROR entry:
  - Capture `wbm_adr_i` and `wbm_owner_i`; set `err_timeout_o`.
  - Pulse `err_o`; increment `err_cnt_o`, saturating at 255.
- Outside ACTIVE (IDLE or ERROR), `wbm_dat_o` = 32'hFFFF_FFFF.

## Timing
- Reset values: state IDLE, `slv_q` 0, counter 0.
  - All `wbs_cyc_o`/`wbs_stb_o`, `wbm_ack_o`, `err_*` and `err_cnt_o` are 0.
  - Assertion is immediate, including mid-cycle; no ack is produced while `wb_rstn_i` is low.
- Mapped access: zero added latency. Slave ack to master ack is combinational.
- Unmapped access: first error ack 2 cycles after `stb` (ERROR entered at cycle +1, ack at +2).
- Timeout: ERROR entered at the `TIMEOUT`th waiting edge, error ack one cycle later.
- `cyc` dropped while waiting: slave `cyc` falls in the same cycle; counter cleared; no error.
- Slave ack arriving on the same edge the counter hits `TIMEOUT`: the ack wins, and no error is logged.
- Back-to-back cycles: `cyc` low for one cycle returns the FSM to IDLE; a new decode happens on the next `cyc&stb`.

## Structure
- Shared package `wb_pkg`: FSM state encoding, error data constant 32'hFFFF_FFFF, default window bases and masks.
- One sub-module, `wb_addr_match`: combinational base/mask compare returning a 4-bit hit vector and 2-bit priority index. The FSM, counter and logging live in the top.

## Test plan
- Read 0x8100_0010, slave 2 acks after 3 cycles with 0x1234_5678 -> master ack the same cycle; data 0x1234_5678; only `wbs_cyc_o[2]` high; `err_o` stays 0.
- Incrementing burst of 4 at 0x0000_0100 (`cti` 010 then 111) -> all 4 beats routed to slave 0; `wbs_cyc_o` stays 4'b0001 throughout.
- Write to 0x9000_0000 with owner 3 -> ack at +2 with data 0xFFFFFFFF; `err_adr_o` 0x9000_0000; `err_owner_o` 3; `err_timeout_o` 0; `err_cnt_o` 1.
- `TIMEOUT` = 4, slave 1 never acks -> ERROR entered at the 4th waiting edge and ack one cycle later; `wbs_cyc_o[1]` drops; `err_timeout_o` 1.
- Slave ack on the same edge the counter reaches `TIMEOUT` -> normal ack; no error logged.
- Reset asserted while ACTIVE with slave 3 -> `wbs_cyc_o` 0 immediately; after release, an access to 0x8000_0000 decodes to slave 1.
